// File: rtl/mux2_arbiter_if.sv
// -----------------------------------------------------------------------------
// mux2_arbiter_if
// Bundles the two requester channels and the single output channel of the
// shared 2:1 data mux arbiter.
//
//   req0/d0, req1/d1 : requester strobes and data (requester -> arbiter)
//   gnt0/gnt1        : grant to requester 0 / 1 (arbiter -> requesters)
//   sel              : mux select, 1 selects d1
//   y/y_valid/y_src  : registered mux output, its valid flag and source tag
//
// master : the requester/consumer side
// slave  : the arbiter
// -----------------------------------------------------------------------------
interface mux2_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0;
    logic [WIDTH-1:0] d0;
    logic             req1;
    logic [WIDTH-1:0] d1;
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_src;

    modport master (
        output req0, d0, req1, d1,
        input  gnt0, gnt1, sel, y, y_valid, y_src
    );

    modport slave (
        input  req0, d0, req1, d1,
        output gnt0, gnt1, sel, y, y_valid, y_src
    );
endinterface

// File: rtl/mux2_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_arbiter
// Round-robin owner of a WIDTH-bit 2:1 data mux shared by two requesters.
// One requester holds the mux at a time; a grant lasts at most MAX_HOLD
// consecutive transfers while the other side is waiting. The selected word is
// registered onto y with a valid flag and a source tag.
//
// Ports:
//   clk      : clock, rising edge
//   reset_n  : synchronous active-low reset
//   bus      : mux2_arbiter_if.slave (req0/d0, req1/d1 in;
//              gnt0, gnt1, sel, y, y_valid, y_src out)
//
// Parameters:
//   WIDTH    : data width (must match the interface instance)
//   MAX_HOLD : transfers per grant while contended, 1..15
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | nobody owns the mux, no transfer
// GRANT0 | requester 0 owns the mux, sel = 0
// GRANT1 | requester 1 owns the mux, sel = 1
// -----------------------------------------------------------------------------
module mux2_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    mux2_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Value of hold_cnt on the final transfer a grant may make while contended.
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t           state_q;
    state_t           state_d;
    logic             last_q;
    logic [3:0]       hold_cnt;
    logic             transfer;
    logic             hold_at_last;
    logic [WIDTH-1:0] mux_data;
    logic             gnt0_c;
    logic             gnt1_c;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic             y_src_q;

    assign hold_at_last = (hold_cnt == HOLD_LAST);
    assign transfer     = ((state_q == GRANT0) && bus.req0) ||
                          ((state_q == GRANT1) && bus.req1);
    assign mux_data     = gnt1_c ? bus.d1 : bus.d0;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    // Tie goes to whoever was not served last.
                    state_d = last_q ? GRANT0 : GRANT1;
                end else if (bus.req0) begin
                    state_d = GRANT0;
                end else if (bus.req1) begin
                    state_d = GRANT1;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT0: begin
                if (!bus.req0) begin
                    state_d = bus.req1 ? GRANT1 : IDLE;
                end else if (hold_at_last && bus.req1) begin
                    state_d = GRANT1;
                end else begin
                    state_d = GRANT0;
                end
            end
            GRANT1: begin
                if (!bus.req1) begin
                    state_d = bus.req0 ? GRANT0 : IDLE;
                end else if (hold_at_last && bus.req0) begin
                    state_d = GRANT0;
                end else begin
                    state_d = GRANT1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode: grants come straight from the state flops, so there is
    // no combinational path from the requester inputs.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        case (state_q)
            GRANT0:  gnt0_c = 1'b1;
            GRANT1:  gnt1_c = 1'b1;
            default: begin
                gnt0_c = 1'b0;
                gnt1_c = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Hold counter and round-robin pointer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hold_cnt <= 4'd0;
            last_q   <= 1'b1;
        end else begin
            if (state_d != state_q) begin
                hold_cnt <= 4'd0;
            end else if (transfer) begin
                // Uncontended grant at its limit keeps going with a fresh count.
                hold_cnt <= hold_at_last ? 4'd0 : hold_cnt + 4'd1;
            end

            if ((state_q == GRANT0) && (state_d != GRANT0)) begin
                last_q <= 1'b0;
            end else if ((state_q == GRANT1) && (state_d != GRANT1)) begin
                last_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registered output channel
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_src_q   <= 1'b0;
        end else if (transfer) begin
            y_q       <= mux_data;
            y_valid_q <= 1'b1;
            y_src_q   <= gnt1_c;
        end else begin
            y_valid_q <= 1'b0;
        end
    end

    assign bus.gnt0    = gnt0_c;
    assign bus.gnt1    = gnt1_c;
    assign bus.sel     = gnt1_c;
    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_src   = y_src_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_arbiter
// Directed vector table, hand-written reset-mid-grant sequence, then random
// traffic checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_mux2_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic reset_n;

    mux2_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux2_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       rn;
        logic       r0;
        logic [3:0] d0;
        logic       r1;
        logic [3:0] d1;
        logic       eg0;
        logic       eg1;
        logic [3:0] ey;
        logic       ev;
        logic       es;
    } vec_t;

    vec_t tbl[$];

    // Reference model: who owns the mux, how many words it has moved in this
    // grant, who was served last, and the output channel contents.
    int       m_owner;   // -1 none, 0 or 1
    int       m_moved;
    int       m_last;
    int       m_y;
    int       m_valid;
    int       m_src;

    task automatic add(input logic rn, input logic r0, input logic [3:0] d0,
                       input logic r1, input logic [3:0] d1,
                       input logic g0, input logic g1, input logic [3:0] y,
                       input logic v, input logic s);
        vec_t e;
        e.rn = rn; e.r0 = r0; e.d0 = d0; e.r1 = r1; e.d1 = d1;
        e.eg0 = g0; e.eg1 = g1; e.ey = y; e.ev = v; e.es = s;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rn, input logic r0, input logic [3:0] d0,
                              input logic r1, input logic [3:0] d1);
        int req[2];
        int dat[2];
        int x;
        int o;
        req[0] = int'(r0); req[1] = int'(r1);
        dat[0] = int'(d0); dat[1] = int'(d1);
        if (!rn) begin
            m_owner = -1; m_moved = 0; m_last = 1;
            m_y = 0; m_valid = 0; m_src = 0;
        end else if (m_owner < 0) begin
            m_valid = 0;
            m_moved = 0;
            if (req[0] != 0 && req[1] != 0) m_owner = 1 - m_last;
            else if (req[0] != 0)           m_owner = 0;
            else if (req[1] != 0)           m_owner = 1;
        end else begin
            x = m_owner;
            o = 1 - x;
            if (req[x] == 0) begin
                m_valid = 0;
                m_last  = x;
                m_moved = 0;
                m_owner = (req[o] != 0) ? o : -1;
            end else begin
                m_y     = dat[x];
                m_src   = x;
                m_valid = 1;
                m_moved = m_moved + 1;
                if (m_moved == MAX_HOLD) begin
                    m_moved = 0;
                    if (req[o] != 0) begin
                        m_last  = x;
                        m_owner = o;
                    end
                end
            end
        end
    endtask

    // Drive on the falling edge, let the rising edge happen, sample 1 time unit
    // later. The model advances with the same inputs.
    task automatic step(input logic rn, input logic r0, input logic [3:0] d0,
                        input logic r1, input logic [3:0] d1);
        @(negedge clk);
        reset_n  = rn;
        bus.req0 = r0;
        bus.d0   = d0;
        bus.req1 = r1;
        bus.d1   = d1;
        model_step(rn, r0, d0, r1, d1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " gnt0"},    int'(bus.gnt0),    (m_owner == 0) ? 1 : 0);
        chk({tag, " gnt1"},    int'(bus.gnt1),    (m_owner == 1) ? 1 : 0);
        chk({tag, " sel"},     int'(bus.sel),     (m_owner == 1) ? 1 : 0);
        chk({tag, " y"},       int'(bus.y),       m_y);
        chk({tag, " y_valid"}, int'(bus.y_valid), m_valid);
        chk({tag, " y_src"},   int'(bus.y_src),   m_src);
    endtask

    initial begin
        reset_n  = 1'b0;
        bus.req0 = 1'b0;
        bus.d0   = '0;
        bus.req1 = 1'b0;
        bus.d1   = '0;
        m_owner = -1; m_moved = 0; m_last = 1;
        m_y = 0; m_valid = 0; m_src = 0;

        //   rn r0 d0    r1 d1     g0 g1 y     v  s
        // reset held with both requesting
        add(0, 1, 4'h0, 1, 4'h0,  0, 0, 4'h0, 0, 0);
        add(0, 1, 4'h0, 1, 4'h0,  0, 0, 4'h0, 0, 0);
        add(0, 1, 4'h0, 1, 4'h0,  0, 0, 4'h0, 0, 0);
        // release: tie after reset goes to requester 0
        add(1, 1, 4'h3, 1, 4'h0,  1, 0, 4'h0, 0, 0);
        // single requester, grant persists past MAX_HOLD transfers
        add(1, 1, 4'h3, 0, 4'h0,  1, 0, 4'h3, 1, 0);
        add(1, 1, 4'h5, 0, 4'h0,  1, 0, 4'h5, 1, 0);
        add(1, 1, 4'h7, 0, 4'h0,  1, 0, 4'h7, 1, 0);
        add(1, 1, 4'h9, 0, 4'h0,  1, 0, 4'h9, 1, 0);
        add(1, 1, 4'h1, 0, 4'h0,  1, 0, 4'h1, 1, 0);
        add(1, 0, 4'h1, 0, 4'h0,  0, 0, 4'h1, 0, 0);
        // saturated contention; requester 0 was served last so 1 wins the tie
        add(1, 1, 4'hA, 1, 4'h5,  0, 1, 4'h1, 0, 0);
        add(1, 1, 4'hA, 1, 4'h5,  0, 1, 4'h5, 1, 1);
        add(1, 1, 4'hA, 1, 4'h5,  0, 1, 4'h5, 1, 1);
        add(1, 1, 4'hA, 1, 4'h5,  0, 1, 4'h5, 1, 1);
        add(1, 1, 4'hA, 1, 4'h5,  1, 0, 4'h5, 1, 1);
        add(1, 1, 4'hA, 1, 4'h5,  1, 0, 4'hA, 1, 0);
        add(1, 1, 4'hA, 1, 4'h5,  1, 0, 4'hA, 1, 0);
        add(1, 1, 4'hA, 1, 4'h5,  1, 0, 4'hA, 1, 0);
        add(1, 1, 4'hA, 1, 4'h5,  0, 1, 4'hA, 1, 0);
        add(1, 1, 4'hA, 1, 4'h5,  0, 1, 4'h5, 1, 1);
        // requester 1 alone, then both drop, then tie: requester 0 wins
        add(1, 0, 4'hA, 1, 4'h5,  0, 1, 4'h5, 1, 1);
        add(1, 0, 4'hA, 0, 4'h5,  0, 0, 4'h5, 0, 1);
        add(1, 1, 4'hA, 1, 4'h5,  1, 0, 4'h5, 0, 1);
        // early drop after two transfers, requester 1 gets a full fresh quota
        add(1, 1, 4'h2, 1, 4'h5,  1, 0, 4'h2, 1, 0);
        add(1, 1, 4'h4, 1, 4'h5,  1, 0, 4'h4, 1, 0);
        add(1, 0, 4'h4, 1, 4'h6,  0, 1, 4'h4, 0, 0);
        add(1, 1, 4'h4, 1, 4'h6,  0, 1, 4'h6, 1, 1);
        add(1, 1, 4'h4, 1, 4'h7,  0, 1, 4'h7, 1, 1);
        add(1, 1, 4'h4, 1, 4'h8,  0, 1, 4'h8, 1, 1);
        add(1, 1, 4'h4, 1, 4'h9,  1, 0, 4'h9, 1, 1);

        foreach (tbl[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            step(tbl[i].rn, tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1);
            chk({tag, " gnt0"},    int'(bus.gnt0),    int'(tbl[i].eg0));
            chk({tag, " gnt1"},    int'(bus.gnt1),    int'(tbl[i].eg1));
            chk({tag, " sel"},     int'(bus.sel),     int'(tbl[i].eg1));
            chk({tag, " y"},       int'(bus.y),       int'(tbl[i].ey));
            chk({tag, " y_valid"}, int'(bus.y_valid), int'(tbl[i].ev));
            chk({tag, " y_src"},   int'(bus.y_src),   int'(tbl[i].es));
        end

        // Reset in the middle of a GRANT1 with two transfers done.
        step(1, 0, 4'h0, 1, 4'h3);
        chk("midrst enter gnt1", int'(bus.gnt1), 1);
        step(1, 0, 4'h0, 1, 4'h3);
        chk("midrst xfer1 y", int'(bus.y), 3);
        step(1, 0, 4'h0, 1, 4'h4);
        chk("midrst xfer2 y", int'(bus.y), 4);
        step(0, 1, 4'h5, 1, 4'h5);
        chk("midrst gnt1", int'(bus.gnt1), 0);
        chk("midrst gnt0", int'(bus.gnt0), 0);
        chk("midrst y_valid", int'(bus.y_valid), 0);
        chk("midrst y", int'(bus.y), 0);
        step(1, 1, 4'h6, 1, 4'h7);
        chk("midrst tie gnt0", int'(bus.gnt0), 1);
        chk("midrst tie gnt1", int'(bus.gnt1), 0);
        step(1, 1, 4'h6, 1, 4'h7);
        chk_model("midrst post");

        // Random traffic with occasional resets.
        step(0, 0, 4'h0, 0, 4'h0);
        chk_model("rnd reset");
        for (int n = 0; n < 3000; n++) begin
            logic       rn;
            logic       r0;
            logic       r1;
            logic [3:0] a0;
            logic [3:0] a1;
            rn = ($urandom_range(0, 99) != 0);
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 3) != 0);
            a0 = 4'($urandom);
            a1 = 4'($urandom);
            step(rn, r0, a0, r1, a1);
            chk_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
